req_dispatcher: RTL and testbench

//   Distributes request IDs from the request FIFO (AXI-Stream) to NUM_CH receiving cores, one ID per core.

---
 rtl/req_dispatch_pkg.sv | 17 +
 rtl/req_dispatcher_rr_arbiter.sv | 23 ++
 rtl/req_dispatcher.sv | 124 ++++++++++++
 tb/tb_req_dispatcher.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_dispatch_pkg.sv
// req_dispatch_pkg: FSM encodings and sizing helpers shared by req_dispatcher and its arbiter.
package req_dispatch_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/req_dispatcher_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first requester at or above ptr (wrapping).
module rr_arbiter
    import req_dispatch_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int PW     = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant
);
    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the closest requester to ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_CH);
            if (req[idx]) grant = NUM_CH'(1) << idx;
        end
    end
endmodule

// File: rtl/req_dispatcher.sv
// req_dispatcher: credit-gated round-robin distribution of FIFO request IDs to NUM_CH cores.
// Define REQ_DISPATCH_STATS_EN to add per-channel 32-bit grant counters on ch_dispatch_cnt.
module req_dispatcher
    import req_dispatch_pkg::*;
#(
    parameter int REQ_ID_WIDTH = 32,
    parameter int NUM_CH       = 2,
    parameter int CREDITS      = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [REQ_ID_WIDTH-1:0]        FIFO_TDATA,
    input  logic                           FIFO_TVALID,
    output logic                           FIFO_TREADY,
    input  logic                           enable,
    output logic [NUM_CH*REQ_ID_WIDTH-1:0] ch_req_id,
    output logic [NUM_CH-1:0]              ch_req_valid,
    input  logic [NUM_CH-1:0]              ch_req_ready,
    input  logic [NUM_CH-1:0]              ch_done,
    output logic                           idle,
    output logic                           credit_err
`ifdef REQ_DISPATCH_STATS_EN
    ,
    output logic [NUM_CH*32-1:0]           ch_dispatch_cnt
`endif
);
    localparam int              CW   = clog2(CREDITS + 1);
    localparam int              PW   = clog2(NUM_CH);
    localparam logic [CW-1:0]   CMAX = CW'(CREDITS);

    logic [1:0]                             state_q, state_d;
    logic [PW-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0][CW-1:0]              credits_q, credits_d;
    logic [NUM_CH-1:0][REQ_ID_WIDTH-1:0]    id_q, id_d;
    logic [NUM_CH-1:0]                      valid_q, valid_d, eligible, arb_grant, grant;
    logic                                   idle_q, idle_d, err_q, err_d, all_home, fire;

    always_comb begin
        eligible = '0;
        all_home = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            eligible[k] = (credits_q[k] != '0) && (!valid_q[k] || ch_req_ready[k]);
            all_home    = all_home && (credits_q[k] == CMAX);
        end
    end

    assign FIFO_TREADY = (state_q == S_RUN) && |eligible;
    assign fire        = FIFO_TVALID && FIFO_TREADY;
    assign grant       = fire ? arb_grant : '0;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    // A grant and a done on the same channel cancel, so the credit stays put.
    always_comb begin
        valid_d   = (valid_q & ~ch_req_ready) | grant;
        id_d      = id_q;
        credits_d = credits_q;
        err_d     = err_q;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                id_d[k]  = FIFO_TDATA;
                rr_ptr_d = PW'((k + 1) % NUM_CH);
            end
            if (grant[k] && !ch_done[k]) credits_d[k] = credits_q[k] - CW'(1);
            else if (!grant[k] && ch_done[k]) begin
                if (credits_q[k] == CMAX) err_d = 1'b1;
                else credits_d[k] = credits_q[k] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = (state_q == S_IDLE) ? (enable ? S_RUN : S_IDLE) :
                  (state_q == S_RUN)  ? (enable ? S_RUN : S_DRAIN) :
                  enable ? S_RUN : ((valid_q == '0 && all_home) ? S_IDLE : S_DRAIN);
        idle_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            credits_q <= {NUM_CH{CMAX}};
            id_q      <= '0;
            valid_q   <= '0;
            idle_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
        end
    end

    assign ch_req_id    = id_q;
    assign ch_req_valid = valid_q;
    assign idle         = idle_q;
    assign credit_err   = err_q;

`ifdef REQ_DISPATCH_STATS_EN
    logic [NUM_CH-1:0][31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_CH; k++) cnt_d[k] = cnt_q[k] + (grant[k] ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign ch_dispatch_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_req_dispatcher.sv
// tb_req_dispatcher: scoreboard bench for req_dispatcher (NUM_CH=2, CREDITS=4, 32-bit IDs).
module tb_req_dispatcher;
    import req_dispatch_pkg::*;
    localparam int W = 32;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [W-1:0]   FIFO_TDATA = '0;
    logic           FIFO_TVALID = 1'b0;
    logic           FIFO_TREADY;
    logic           enable = 1'b0;
    logic [N*W-1:0] ch_req_id;
    logic [N-1:0]   ch_req_valid;
    logic [N-1:0]   ch_req_ready = '0;
    logic [N-1:0]   ch_done = '0;
    logic           idle;
    logic           credit_err;
`ifdef REQ_DISPATCH_STATS_EN
    logic [N*32-1:0] cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] sb [N][$];

    always #5 clk = ~clk;

    req_dispatcher #(.REQ_ID_WIDTH(W), .NUM_CH(N), .CREDITS(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .FIFO_TDATA   (FIFO_TDATA),
        .FIFO_TVALID  (FIFO_TVALID),
        .FIFO_TREADY  (FIFO_TREADY),
        .enable       (enable),
        .ch_req_id    (ch_req_id),
        .ch_req_valid (ch_req_valid),
        .ch_req_ready (ch_req_ready),
        .ch_done      (ch_done),
        .idle         (idle),
        .credit_err   (credit_err)
`ifdef REQ_DISPATCH_STATS_EN
        ,
        .ch_dispatch_cnt (cnt)
`endif
    );

    // One clock: pop the scoreboard for every core-side handshake, then step past the edge.
    task automatic cycle();
        logic [W-1:0] got, exp;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (ch_req_valid[k] && ch_req_ready[k]) begin
                got = ch_req_id[ch_lo(k, W) +: W];
                n_cmp++;
                if (sb[k].size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_ch%0d: delivered id %0d, expected nothing pending", k, got);
                end else begin
                    exp = sb[k].pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL sb_ch%0d: delivered id %0d, expected %0d", k, got, exp);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] id, input int ch, input logic [N-1:0] dn);
        bit ok = 1'b0;
        sb[ch].push_back(id);
        FIFO_TDATA  = id;
        FIFO_TVALID = 1'b1;
        ch_done     = dn;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = FIFO_TREADY;
            cycle();
            ch_done = '0;
        end
        FIFO_TVALID = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_%0d: not accepted in 20 cycles, expected accept for ch%0d", id, ch);
            void'(sb[ch].pop_back());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 5;
        if (FIFO_TREADY !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b expected 0", FIFO_TREADY); end
        if (ch_req_valid !== '0) begin n_bad++; $display("FAIL rst_valid: got %b expected 00", ch_req_valid); end
        if (ch_req_id !== '0) begin n_bad++; $display("FAIL rst_id: got %h expected 0", ch_req_id); end
        if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b expected 1", idle); end
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", credit_err); end
        resetn = 1'b1;
        cycle();
    endtask

    task automatic test_back_to_back();
        ch_req_ready = 2'b11;
        enable = 1'b1;
        cycle();
        n_cmp++;
        if (idle !== 1'b0) begin n_bad++; $display("FAIL run_idle: got %b expected 0", idle); end
        for (int i = 1; i <= 4; i++) begin
            send(W'(i), (i - 1) % 2, 2'b00);
            n_cmp++;
            if (ch_req_valid[(i - 1) % 2] !== 1'b1 || ch_req_id[ch_lo((i - 1) % 2, W) +: W] !== W'(i)) begin
                n_bad++;
                $display("FAIL b2b_latency_%0d: valid %b id %0d, expected valid 1 id %0d", i,
                         ch_req_valid[(i - 1) % 2], ch_req_id[ch_lo((i - 1) % 2, W) +: W], i);
            end
        end
`ifdef REQ_DISPATCH_STATS_EN
        n_cmp++;
        if (cnt !== {32'd2, 32'd2}) begin n_bad++; $display("FAIL stats_cnt: got %h expected {2,2}", cnt); end
`endif
        ch_done = 2'b11;
        cycle();
        cycle();
        ch_done = 2'b00;
    endtask

    task automatic test_credit_limit();
        int ch;
        for (int i = 0; i < 12; i++) begin
            ch = (i < 8) ? i % 2 : 1;
            send(W'(11 + i), ch, 2'b00);
            if (i < 8 && ch == 1) begin
                ch_done = 2'b10;
                cycle();
                ch_done = 2'b00;
            end
        end
        FIFO_TDATA  = 99;
        FIFO_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (FIFO_TREADY !== 1'b0) begin n_bad++; $display("FAIL nocredit_tready_%0d: got %b expected 0", i, FIFO_TREADY); end
            cycle();
        end
        FIFO_TVALID = 1'b0;
        ch_done = 2'b11;
        repeat (4) cycle();
        ch_done = 2'b00;
        n_cmp++;
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL limit_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_stall();
        ch_req_ready = 2'b11;
        send(31, 0, 2'b00);
        ch_req_ready = 2'b01;
        send(32, 1, 2'b00);
        for (int j = 0; j < 5; j++) begin
            if (j < 3) begin
                FIFO_TDATA  = W'(33 + j);
                FIFO_TVALID = 1'b1;
                sb[0].push_back(W'(33 + j));
                n_cmp++;
                if (FIFO_TREADY !== 1'b1) begin n_bad++; $display("FAIL stall_tready_%0d: got %b expected 1", j, FIFO_TREADY); end
            end else FIFO_TVALID = 1'b0;
            n_cmp++;
            if (ch_req_valid[1] !== 1'b1 || ch_req_id[ch_lo(1, W) +: W] !== W'(32)) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: valid %b id %0d, expected valid 1 id 32", j,
                         ch_req_valid[1], ch_req_id[ch_lo(1, W) +: W]);
            end
            cycle();
        end
        FIFO_TVALID = 1'b0;
        ch_req_ready = 2'b11;
        cycle();
        ch_done = 2'b11;
        cycle();
        ch_done = 2'b01;
        repeat (3) cycle();
        ch_done = 2'b00;
    endtask

    task automatic test_same_cycle_done();
        for (int i = 0; i < 7; i++) send(W'(41 + i), (i % 2 == 0) ? 1 : 0, 2'b00);
        send(48, 0, 2'b01);
        send(49, 0, 2'b00);
        n_cmp++;
        if (FIFO_TREADY !== 1'b0) begin n_bad++; $display("FAIL same_cycle_credit: tready %b expected 0", FIFO_TREADY); end
        ch_done = 2'b11;
        repeat (4) cycle();
        ch_done = 2'b00;
        n_cmp++;
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b expected 0", credit_err); end
        ch_done = 2'b01;
        cycle();
        ch_done = 2'b00;
        n_cmp++;
        if (credit_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", credit_err); end
        repeat (3) cycle();
        n_cmp++;
        if (credit_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", credit_err); end
    endtask

    task automatic test_drain();
        send(51, 1, 2'b00);
        send(52, 0, 2'b00);
        send(53, 1, 2'b00);
        enable = 1'b0;
        cycle();
        FIFO_TDATA  = 98;
        FIFO_TVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (FIFO_TREADY !== 1'b0) begin n_bad++; $display("FAIL drain_tready_%0d: got %b expected 0", i, FIFO_TREADY); end
            cycle();
        end
        FIFO_TVALID = 1'b0;
        n_cmp++;
        if (idle !== 1'b0) begin n_bad++; $display("FAIL drain_busy: idle %b expected 0", idle); end
        ch_done = 2'b11;
        cycle();
        ch_done = 2'b10;
        cycle();
        ch_done = 2'b00;
        for (int i = 0; i < 5 && idle !== 1'b1; i++) cycle();
        n_cmp++;
        if (idle !== 1'b1) begin n_bad++; $display("FAIL drain_idle: got %b expected 1", idle); end
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        cycle();
        ch_req_ready = 2'b00;
        send(61, 0, 2'b00);
        n_cmp += 2;
        if (ch_req_valid[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid: got %b expected 1", ch_req_valid[0]); end
        if (idle !== 1'b0) begin n_bad++; $display("FAIL pre_rst_idle: got %b expected 0", idle); end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp += 5;
        if (FIFO_TREADY !== 1'b0) begin n_bad++; $display("FAIL arst_tready: got %b expected 0", FIFO_TREADY); end
        if (ch_req_valid !== '0) begin n_bad++; $display("FAIL arst_valid: got %b expected 00", ch_req_valid); end
        if (ch_req_id !== '0) begin n_bad++; $display("FAIL arst_id: got %h expected 0", ch_req_id); end
        if (idle !== 1'b1) begin n_bad++; $display("FAIL arst_idle: got %b expected 1", idle); end
        if (credit_err !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b expected 0", credit_err); end
`ifdef REQ_DISPATCH_STATS_EN
        n_cmp++;
        if (cnt !== '0) begin n_bad++; $display("FAIL arst_cnt: got %h expected 0", cnt); end
`endif
        sb[0].delete();
        enable = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_credit_limit();
        test_stall();
        test_same_cycle_done();
        test_drain();
        test_async_reset();
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (sb[k].size() != 0) begin n_bad++; $display("FAIL sb_leftover_ch%0d: %0d ids undelivered, expected 0", k, sb[k].size()); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
